// File: rtl/line_pkg.sv
// Shared types for the line rasterizer and the primitive sequencers
// that will feed it.
`timescale 1ns/1ps
package line_pkg;

  localparam int COORD_W_DEF = 10;
  localparam int ERR_W_DEF   = COORD_W_DEF + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;

endpackage

// File: rtl/line_raster.sv
// Bresenham line rasterizer, one signed pixel per clock in any octant.
// Output coordinates are origin-centred; the clip stage maps them.
`timescale 1ns/1ps
module line_raster
  import line_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ERR_W   = COORD_W + 3
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  output logic                      busy,
  output logic                      writeEn,
  output logic signed [COORD_W-1:0] x,
  output logic signed [COORD_W-1:0] y,
  output logic                      done
);

  localparam int MW = COORD_W + 1;

  typedef logic signed [COORD_W-1:0] crd_t;
  typedef logic signed [ERR_W-1:0]   err_t;

  localparam crd_t ONE = crd_t'(1);

  state_e state_q;
  crd_t   x_q, y_q;
  crd_t   x1_q, y1_q;
  err_t   dx_q, dy_q, err_q;
  logic   sxn_q, syn_q;
  logic   we_q, done_q;

  logic signed [MW-1:0] ddx, ddy;
  logic [MW-1:0]        adx, ady;
  err_t                 dx_d, dy_d;

  // Magnitudes need one extra bit: the span reaches 2^COORD_W - 1.
  always_comb begin
    ddx  = MW'(x1) - MW'(x0);
    ddy  = MW'(y1) - MW'(y0);
    adx  = ddx[MW-1] ? -ddx : ddx;
    ady  = ddy[MW-1] ? -ddy : ddy;
    dx_d = err_t'(adx);
    dy_d = -err_t'(ady);
  end

  err_t e2, err_d;
  crd_t xs_d, ys_d;
  logic at_end;

  always_comb begin
    e2    = err_q <<< 1;
    err_d = err_q;
    xs_d  = x_q;
    ys_d  = y_q;
    if (e2 >= dy_q) begin
      err_d = err_d + dy_q;
      xs_d  = sxn_q ? x_q - ONE : x_q + ONE;
    end
    if (e2 <= dx_q) begin
      err_d = err_d + dx_q;
      ys_d  = syn_q ? y_q - ONE : y_q + ONE;
    end
    at_end = (x_q == x1_q) && (y_q == y1_q);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sxn_q   <= 1'b0;
      syn_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          we_q   <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            x1_q    <= x1;
            y1_q    <= y1;
            x_q     <= x0;
            y_q     <= y0;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= dx_d + dy_d;
            sxn_q   <= !(x0 < x1);
            syn_q   <= !(y0 < y1);
            we_q    <= 1'b1;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (at_end) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            x_q   <= xs_d;
            y_q   <= ys_d;
            err_q <= err_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign writeEn = we_q;
  assign x       = x_q;
  assign y       = y_q;
  assign done    = done_q;

endmodule

// File: tb/tb_line_raster.sv
// Directed and random line tests for line_raster against a
// plain-integer Bresenham reference.
`timescale 1ns/1ps
module tb_line_raster;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic signed [9:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic busy, writeEn, done;
  logic signed [9:0] x, y;

  line_raster dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .x0     (x0),
    .y0     (y0),
    .x1     (x1),
    .y1     (y1),
    .busy   (busy),
    .writeEn(writeEn),
    .x      (x),
    .y      (y),
    .done   (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
  } pix_t;

  pix_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic px(input int ax, input int ay);
    pix_t p;
    p.x = ax;
    p.y = ay;
    exp_q.push_back(p);
  endtask

  // Reference: the textbook integer Bresenham walk.
  task automatic model(input int ax0, input int ay0,
                       input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, cx, cy;
    exp_q.delete();
    dx  = iabs(ax1 - ax0);
    dy  = -iabs(ay1 - ay0);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    cx  = ax0;
    cy  = ay0;
    for (int k = 0; k < 5000; k++) begin
      px(cx, cy);
      if (cx == ax1 && cy == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  task automatic launch(input int ax0, input int ay0,
                        input int ax1, input int ay1);
    x0 = 10'(ax0);
    y0 = 10'(ay0);
    x1 = 10'(ax1);
    y1 = 10'(ay1);
    start = 1'b1;
  endtask

  // Called just after launch; walks every cycle of the line.
  task automatic follow(input string nm);
    pix_t last;
    @(posedge clock);
    #1 start = 1'b0;
    x0 = 10'($urandom);
    x1 = 10'($urandom);
    foreach (exp_q[i]) begin
      @(negedge clock);
      check($sformatf("%s we%0d", nm, i), int'(writeEn), 1);
      check($sformatf("%s x%0d", nm, i), int'(x), exp_q[i].x);
      check($sformatf("%s y%0d", nm, i), int'(y), exp_q[i].y);
      check($sformatf("%s busy%0d", nm, i), int'(busy), 1);
      check($sformatf("%s done%0d", nm, i), int'(done), 0);
    end
    last = exp_q[exp_q.size()-1];
    @(negedge clock);
    check({nm, " done"}, int'(done), 1);
    check({nm, " done_we"}, int'(writeEn), 0);
    check({nm, " done_busy"}, int'(busy), 1);
    check({nm, " hold_x"}, int'(x), last.x);
    @(negedge clock);
    check({nm, " idle_done"}, int'(done), 0);
    check({nm, " idle_busy"}, int'(busy), 0);
    check({nm, " idle_we"}, int'(writeEn), 0);
    check({nm, " idle_y"}, int'(y), last.y);
  endtask

  initial begin
    int rx0, ry0, rx1, ry1;

    repeat (2) @(negedge clock);
    check("rst busy", int'(busy), 0);
    check("rst we", int'(writeEn), 0);
    check("rst done", int'(done), 0);
    check("rst x", int'(x), 0);
    check("rst y", int'(y), 0);
    resetn = 1'b1;
    @(negedge clock);

    exp_q.delete();
    px(0, 0); px(1, 0); px(2, 0); px(3, 0);
    launch(0, 0, 3, 0);
    follow("horiz");

    exp_q.delete();
    px(0, 0); px(0, -1); px(-1, -2); px(-1, -3); px(-2, -4); px(-2, -5);
    launch(0, 0, -2, -5);
    follow("steep");

    exp_q.delete();
    px(5, -7);
    launch(5, -7, 5, -7);
    follow("point");

    // Start held high through a busy line: new endpoints ignored
    // until the rasterizer returns to idle.
    launch(0, 0, 3, 3);
    @(posedge clock);
    #1 x0 = 10'(10); y0 = 10'(10); x1 = 10'(12); y1 = 10'(10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("hold we%0d", i), int'(writeEn), 1);
      check($sformatf("hold x%0d", i), int'(x), i);
      check($sformatf("hold y%0d", i), int'(y), i);
    end
    @(negedge clock);
    check("hold done", int'(done), 1);
    check("hold x_last", int'(x), 3);
    @(negedge clock);
    check("hold idle", int'(busy), 0);
    exp_q.delete();
    px(10, 10); px(11, 10); px(12, 10);
    follow("second");

    model(-512, 0, 511, 0);
    check("span_h n", exp_q.size(), 1024);
    launch(-512, 0, 511, 0);
    follow("span_h");

    model(0, -512, 0, 511);
    launch(0, -512, 0, 511);
    follow("span_v");

    model(-512, -512, 511, 511);
    launch(-512, -512, 511, 511);
    follow("span_d");

    model(511, -512, -512, 300);
    launch(511, -512, -512, 300);
    follow("span_a");

    // Async reset between edges at the third pixel of a 10-pixel line.
    launch(0, 0, 9, 0);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_rst x", int'(x), 2);
    #2 resetn = 1'b0;
    #1;
    check("arst we", int'(writeEn), 0);
    check("arst busy", int'(busy), 0);
    check("arst done", int'(done), 0);
    check("arst x", int'(x), 0);
    check("arst y", int'(y), 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("post_rst we%0d", i), int'(writeEn), 0);
      check($sformatf("post_rst busy%0d", i), int'(busy), 0);
    end

    for (int t = 0; t < 24; t++) begin
      if (t < 12) begin
        rx0 = int'($urandom_range(40)) - 20;
        ry0 = int'($urandom_range(40)) - 20;
        rx1 = int'($urandom_range(40)) - 20;
        ry1 = int'($urandom_range(40)) - 20;
      end else begin
        rx0 = int'($urandom_range(1023)) - 512;
        ry0 = int'($urandom_range(1023)) - 512;
        rx1 = int'($urandom_range(1023)) - 512;
        ry1 = int'($urandom_range(1023)) - 512;
      end
      model(rx0, ry0, rx1, ry1);
      launch(rx0, ry0, rx1, ry1);
      follow($sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_raster.md
Name: line_raster

Overview:
- Bresenham line rasterizer placed directly upstream of the screen-mapping/clip stage.
- Accepts two signed world-space endpoints and emits one pixel coordinate per clock, with a write-enable strobe, covering all octants.
- Output x/y are signed two's-complement, origin-centred values, consumed unchanged by the clip stage, which does screen offset and bounds rejection.

Parameters:
- COORD_W, 10: width of signed endpoint and output coordinates.
- ERR_W, COORD_W+3: width of signed Bresenham error accumulator and doubled-error term.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- x0  in  COORD_W  signed start x
- y0  in  COORD_W  signed start y
- x1  in  COORD_W  signed end x
- y1  in  COORD_W  signed end y
- busy  out  1  high whenever state is not IDLE
- writeEn  out  1  pixel valid this cycle
- x  out  COORD_W  signed pixel x
- y  out  COORD_W  signed pixel y
- done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (resetn=0, asynchronous, any state): state=IDLE; busy=0, writeEn=0, done=0, x=0, y=0; all internal registers cleared. Reset mid-line abandons the line with no further pixels.
- States: IDLE, DRAW, DONE.
- IDLE:
  - start=1 latches x0..y1 and computes: dx=|x1-x0|; dy=-|y1-y0|; sx=(x0<x1)?+1:-1; sy=(y0<y1)?+1:-1; err=dx+dy; cur=(x0,y0).
  - Next state is DRAW.
  - start=0 keeps IDLE.
- DRAW:
  - writeEn=1; x,y=cur (registered, no combinational path from inputs).
  - If cur==(x1,y1), next state is DONE.
  - Otherwise e2=2*err:
    - if e2>=dy: err+=dy, cur_x+=sx
    - if e2<=dx: err+=dx, cur_y+=sy
    - Both updates use the old err and are applied in the same cycle.
- DONE: writeEn=0, done=1 for exactly one cycle, then IDLE.
- Timing: start accepted at cycle 0.
  - Pixels appear in cycles 1..N, where N=max(dx,-dy)+1.
  - done is high in cycle N+1.
  - busy is high in cycles 1..N+1.
  - A new start is accepted at the earliest in cycle N+2.
- start while busy=1 is ignored; endpoint inputs are don't-care after acceptance.
- Degenerate line (x0==x1 and y0==y1): exactly one pixel, then done.
- Widths:
  - dx and |dy| are computed at COORD_W+1 bits; they span 0..1023 for the defaults.
  - err and e2 are signed ERR_W bits and never overflow for any endpoint pair in range.
  - cur_x/cur_y stay within the endpoint span, so no wrap.
- writeEn is low in IDLE and DONE; x/y hold the last pixel after DRAW until the next line.
- No backpressure: the downstream stage accepts one pixel per cycle unconditionally.

Decomposition:
- Shared package line_pkg:
  - COORD_W and ERR_W defaults
  - state enum: IDLE=2'd0, DRAW=2'd1, DONE=2'd2
  - signed coordinate typedef
- Shared by the rasterizer and future triangle/wireframe sequencers.
- Single module; no sub-module needed. Optionally factor abs_diff (signed subtract + magnitude) as a small combinational helper.

Test Plan:
- Horizontal line: (0,0)->(3,0) -> pixels (0,0),(1,0),(2,0),(3,0) in cycles 1-4; done=1 in cycle 5 only; busy low in cycle 6.
- Steep negative octant: (0,0)->(-2,-5) -> exact sequence (0,0),(0,-1),(-1,-2),(-1,-3),(-2,-4),(-2,-5); done the cycle after (-2,-5).
- Single point: (5,-7)->(5,-7) -> one writeEn cycle with x=5, y=-7; done the next cycle.
- Start while busy: start held high with new endpoints during a 4-pixel line -> original 4 pixels unchanged; second line starts only if start is still high once busy=0.
- Extreme span: (-512,0)->(511,0) -> 1024 consecutive pixels, x increments by 1 each cycle, last pixel (511,0), no error overflow. Repeat with (0,-512)->(0,511).
- Async reset mid-line: drop resetn between clock edges at pixel 3 of a 10-pixel line -> writeEn, busy, done, x, y all 0 immediately; after release, no pixels until a new start.
